// File: rtl/ternary_pkg.sv
// Balanced-ternary trit encoding shared by the ternary pipeline.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b10;

endpackage

// File: rtl/ternary_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface ternary_fetch_unit_if #(
    parameter int unsigned PC_TRITS    = 9,
    parameter int unsigned INSTR_TRITS = 9
);
    import ternary_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    trit_t [PC_TRITS-1:0]     req_pc;
    logic                     rsp_valid;
    trit_t [INSTR_TRITS-1:0]  rsp_instr;

    modport master (
        output req_valid,
        output req_pc,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        output req_ready,
        output rsp_valid,
        output rsp_instr
    );

endinterface

// File: rtl/ternary_fetch_unit.sv
// IF stage: balanced-ternary PC, in-order imem requests, small in-order fetch queue.
module ternary_fetch_unit
    import ternary_pkg::*;
#(
    parameter int unsigned PC_TRITS    = 9,
    parameter int unsigned INSTR_TRITS = 9,
    parameter int unsigned FQ_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pc_stall,
    input  logic                    if_id_stall,
    input  logic                    redirect_valid,
    input  trit_t [PC_TRITS-1:0]    redirect_pc,
    ternary_fetch_unit_if.master    imem,
    output logic                    if_valid,
    output trit_t [PC_TRITS-1:0]    if_pc,
    output trit_t [INSTR_TRITS-1:0] if_instr,
    output logic                    fetch_err
);

    typedef trit_t [PC_TRITS-1:0]    pc_t;
    typedef trit_t [INSTR_TRITS-1:0] instr_t;

    localparam int unsigned PtrW = $clog2(FQ_DEPTH);
    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

    // Per-entry lifecycle
    localparam logic [1:0] StEmpty  = 2'd0;
    localparam logic [1:0] StRsvd   = 2'd1;
    localparam logic [1:0] StFilled = 2'd2;

    logic [1:0]      st_q   [FQ_DEPTH];
    logic [1:0]      st_d   [FQ_DEPTH];
    pc_t             epc_q  [FQ_DEPTH];
    pc_t             epc_d  [FQ_DEPTH];
    instr_t          ein_q  [FQ_DEPTH];
    instr_t          ein_d  [FQ_DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    // fill pointer tracks the oldest RESERVED entry (fills happen in order)
    logic [PtrW-1:0] fill_q, fill_d;
    logic [CntW-1:0] drop_q, drop_d;
    pc_t             pc_q, pc_d;
    logic            err_q, err_d;

    logic [CntW-1:0] occ;
    logic [CntW-1:0] n_rsvd;
    logic            req_valid;
    logic            accept;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FQ_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Balanced-ternary +1, carry rippling up from trit 0; top carry is dropped.
    function automatic pc_t pc_inc(input pc_t pc);
        pc_t  r;
        logic carry;
        r     = pc;
        carry = 1'b1;
        for (int i = 0; i < int'(PC_TRITS); i++) begin
            if (carry) begin
                case (pc[i])
                    T_NEG:   begin r[i] = T_ZERO; carry = 1'b0; end
                    T_POS:   begin r[i] = T_NEG;  carry = 1'b1; end
                    default: begin r[i] = T_POS;  carry = 1'b0; end
                endcase
            end
        end
        return r;
    endfunction

    // Occupancy and reserved-entry counts from registered entry state.
    always_comb begin
        occ    = '0;
        n_rsvd = '0;
        for (int i = 0; i < int'(FQ_DEPTH); i++) begin
            if (st_q[i] != StEmpty) occ = occ + CntW'(1);
            if (st_q[i] == StRsvd)  n_rsvd = n_rsvd + CntW'(1);
        end
    end

    assign req_valid = rst_n && !pc_stall && !redirect_valid &&
                       (({1'b0, occ} + {1'b0, drop_q}) < (CntW + 1)'(FQ_DEPTH));
    assign accept    = req_valid && imem.req_ready;
    assign if_valid  = rst_n && (st_q[head_q] == StFilled);
    assign pop       = if_valid && !if_id_stall;

    assign imem.req_valid = req_valid;
    assign imem.req_pc    = pc_q;
    assign if_pc          = if_valid ? epc_q[head_q] : '0;
    assign if_instr       = if_valid ? ein_q[head_q] : '0;
    assign fetch_err      = err_q;

    // Next-state: redirect overrides push/fill; push, fill and pop may coincide.
    always_comb begin
        st_d   = st_q;
        epc_d  = epc_q;
        ein_d  = ein_q;
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        drop_d = drop_q;
        pc_d   = pc_q;
        err_d  = err_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            head_d = '0;
            tail_d = '0;
            fill_d = '0;
            for (int i = 0; i < int'(FQ_DEPTH); i++) st_d[i] = StEmpty;
            if (imem.rsp_valid) begin
                // nothing outstanding to attribute the response to
                if (drop_q == '0 && n_rsvd == '0) err_d = 1'b1;
                else drop_d = drop_q + n_rsvd - CntW'(1);
            end else begin
                drop_d = drop_q + n_rsvd;
            end
        end else begin
            if (imem.rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CntW'(1);
                end else if (st_q[fill_q] == StRsvd) begin
                    st_d[fill_q]  = StFilled;
                    ein_d[fill_q] = imem.rsp_instr;
                    fill_d        = ptr_inc(fill_q);
                end else begin
                    err_d = 1'b1;
                end
            end
            if (accept) begin
                st_d[tail_q]  = StRsvd;
                epc_d[tail_q] = pc_q;
                tail_d        = ptr_inc(tail_q);
                pc_d          = pc_inc(pc_q);
            end
            if (pop) begin
                st_d[head_q] = StEmpty;
                head_d       = ptr_inc(head_q);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                st_q[i]  <= StEmpty;
                epc_q[i] <= '0;
                ein_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
            drop_q <= '0;
            pc_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            epc_q  <= epc_d;
            ein_q  <= ein_d;
            head_q <= head_d;
            tail_q <= tail_d;
            fill_q <= fill_d;
            drop_q <= drop_d;
            pc_q   <= pc_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_ternary_fetch_unit.sv
// Directed bench for ternary_fetch_unit (FQ_DEPTH = 2, 9-trit PC/instr).
module tb_ternary_fetch_unit;
    import ternary_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pc_stall;
    logic        if_id_stall;
    logic        redirect_valid;
    logic [17:0] redirect_pc;
    logic        if_valid;
    logic [17:0] if_pc;
    logic [17:0] if_instr;
    logic        fetch_err;

    int vectors;
    int miscompares;

    ternary_fetch_unit_if #(.PC_TRITS(9), .INSTR_TRITS(9)) imem_if ();

    ternary_fetch_unit #(
        .PC_TRITS    (9),
        .INSTR_TRITS (9),
        .FQ_DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_if),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer -> 9-trit balanced-ternary vector (trit 0 in bits [1:0]).
    function automatic logic [17:0] tv(input int n);
        int          v;
        int          m;
        logic [17:0] r;
        v = n;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            m = ((v % 3) + 3) % 3;
            if (m == 0) begin
                r[2*i +: 2] = T_ZERO;
                v = v / 3;
            end else if (m == 1) begin
                r[2*i +: 2] = T_POS;
                v = (v - 1) / 3;
            end else begin
                r[2*i +: 2] = T_NEG;
                v = (v + 1) / 3;
            end
        end
        return r;
    endfunction

    // Instruction word returned for the request at PC n.
    function automatic logic [17:0] instr_of(input int n);
        return tv(n + 100);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_n              = 1'b0;
        pc_stall           = 1'b0;
        if_id_stall        = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        imem_if.req_ready  = 1'b1;
        imem_if.rsp_valid  = 1'b0;
        imem_if.rsp_instr  = '0;
        tick();

        // Reset state
        #1;
        chk("rst_req_valid", 32'(imem_if.req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_if_instr", 32'(if_instr), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_req_pc", 32'(imem_if.req_pc), 32'(tv(0)));
        tick();

        // Straight-line fetch, 1-cycle response latency
        rst_n = 1'b1;
        #1;
        chk("c0_req_valid", 32'(imem_if.req_valid), 32'd1);
        chk("c0_req_pc", 32'(imem_if.req_pc), 32'(tv(0)));
        chk("c0_if_valid", 32'(if_valid), 32'd0);
        tick();

        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = instr_of(0);
        #1;
        chk("c1_req_pc", 32'(imem_if.req_pc), 32'(tv(1)));
        chk("c1_if_valid", 32'(if_valid), 32'd0);
        tick();

        imem_if.rsp_instr = instr_of(1);
        #1;
        chk("c2_req_valid_full", 32'(imem_if.req_valid), 32'd0);
        chk("c2_if_valid", 32'(if_valid), 32'd1);
        chk("c2_if_pc", 32'(if_pc), 32'(tv(0)));
        chk("c2_if_instr", 32'(if_instr), 32'(instr_of(0)));
        tick();

        imem_if.rsp_valid = 1'b0;
        #1;
        chk("c3_req_pc", 32'(imem_if.req_pc), 32'(tv(2)));
        chk("c3_if_pc", 32'(if_pc), 32'(tv(1)));
        chk("c3_if_instr", 32'(if_instr), 32'(instr_of(1)));
        tick();

        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = instr_of(2);
        #1;
        chk("c4_req_pc", 32'(imem_if.req_pc), 32'(tv(3)));
        chk("c4_if_valid", 32'(if_valid), 32'd0);
        tick();

        imem_if.rsp_instr = instr_of(3);
        #1;
        chk("c5_if_pc", 32'(if_pc), 32'(tv(2)));
        chk("c5_if_instr", 32'(if_instr), 32'(instr_of(2)));
        tick();

        // IF/ID stalls first, then load-use (both stalls) for 3 cycles
        imem_if.rsp_valid = 1'b0;
        if_id_stall = 1'b1;
        #1;
        chk("c6_req_valid", 32'(imem_if.req_valid), 32'd1);
        chk("c6_req_pc", 32'(imem_if.req_pc), 32'(tv(4)));
        chk("c6_if_pc", 32'(if_pc), 32'(tv(3)));
        tick();

        pc_stall = 1'b1;
        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = instr_of(4);
        #1;
        chk("lu0_req_valid", 32'(imem_if.req_valid), 32'd0);
        chk("lu0_if_pc", 32'(if_pc), 32'(tv(3)));
        chk("lu0_if_instr", 32'(if_instr), 32'(instr_of(3)));
        tick();

        imem_if.rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lu_req_valid", 32'(imem_if.req_valid), 32'd0);
            chk("lu_if_valid", 32'(if_valid), 32'd1);
            chk("lu_if_pc", 32'(if_pc), 32'(tv(3)));
            chk("lu_if_instr", 32'(if_instr), 32'(instr_of(3)));
            tick();
        end

        // Resume: queue holds two filled entries, drained in order
        pc_stall = 1'b0;
        if_id_stall = 1'b0;
        #1;
        chk("r0_req_valid_full", 32'(imem_if.req_valid), 32'd0);
        chk("r0_if_pc", 32'(if_pc), 32'(tv(3)));
        tick();

        #1;
        chk("r1_req_pc", 32'(imem_if.req_pc), 32'(tv(5)));
        chk("r1_if_pc", 32'(if_pc), 32'(tv(4)));
        chk("r1_if_instr", 32'(if_instr), 32'(instr_of(4)));
        tick();

        // Two requests in flight, then redirect to +00 (9)
        #1;
        chk("f2_req_pc", 32'(imem_if.req_pc), 32'(tv(6)));
        chk("f2_if_valid", 32'(if_valid), 32'd0);
        tick();

        redirect_valid = 1'b1;
        redirect_pc = tv(9);
        #1;
        chk("rd_req_valid", 32'(imem_if.req_valid), 32'd0);
        tick();

        redirect_valid = 1'b0;
        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = instr_of(5);
        #1;
        chk("drop2_req_valid", 32'(imem_if.req_valid), 32'd0);
        chk("drop2_if_valid", 32'(if_valid), 32'd0);
        tick();

        imem_if.rsp_instr = instr_of(6);
        imem_if.req_ready = 1'b0;
        #1;
        chk("drop1_req_pc", 32'(imem_if.req_pc), 32'(tv(9)));
        chk("drop1_if_valid", 32'(if_valid), 32'd0);
        tick();

        imem_if.rsp_valid = 1'b0;
        imem_if.req_ready = 1'b1;
        #1;
        chk("post_drop_req_valid", 32'(imem_if.req_valid), 32'd1);
        chk("post_drop_req_pc", 32'(imem_if.req_pc), 32'(tv(9)));
        chk("post_drop_if_valid", 32'(if_valid), 32'd0);
        chk("post_drop_err", 32'(fetch_err), 32'd0);
        tick();

        // Redirect to -- (-4) coincident with the response for PC 9
        redirect_valid = 1'b1;
        redirect_pc = tv(-4);
        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = instr_of(9);
        #1;
        chk("rc_if_valid", 32'(if_valid), 32'd0);
        tick();

        redirect_valid = 1'b0;
        imem_if.rsp_valid = 1'b0;
        #1;
        chk("rc_req_valid", 32'(imem_if.req_valid), 32'd1);
        chk("rc_req_pc", 32'(imem_if.req_pc), 32'(tv(-4)));
        chk("rc_err", 32'(fetch_err), 32'd0);
        tick();

        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = instr_of(-4);
        imem_if.req_ready = 1'b0;
        #1;
        chk("rc_next_pc", 32'(imem_if.req_pc), 32'(tv(-3)));
        chk("rc_fill_if_valid", 32'(if_valid), 32'd0);
        tick();

        imem_if.rsp_valid = 1'b0;
        #1;
        chk("rc_out_valid", 32'(if_valid), 32'd1);
        chk("rc_out_pc", 32'(if_pc), 32'(tv(-4)));
        chk("rc_out_instr", 32'(if_instr), 32'(instr_of(-4)));
        chk("rc_out_err", 32'(fetch_err), 32'd0);
        tick();

        // PC wrap-around: all T_POS + 1 = all T_NEG
        redirect_valid = 1'b1;
        redirect_pc = tv(9841);
        imem_if.req_ready = 1'b1;
        #1;
        chk("wr_req_valid", 32'(imem_if.req_valid), 32'd0);
        chk("wr_if_valid", 32'(if_valid), 32'd0);
        tick();

        redirect_valid = 1'b0;
        #1;
        chk("wr_req_pc_pos", 32'(imem_if.req_pc), 32'(tv(9841)));
        tick();

        imem_if.req_ready = 1'b0;
        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = tv(-50);
        #1;
        chk("wr_req_pc_neg", 32'(imem_if.req_pc), 32'(tv(-9841)));
        tick();

        imem_if.rsp_valid = 1'b0;
        #1;
        chk("wr_if_pc", 32'(if_pc), 32'(tv(9841)));
        chk("wr_if_instr", 32'(if_instr), 32'(tv(-50)));
        tick();

        // Spurious response with an empty queue and no pending drops
        imem_if.rsp_valid = 1'b1;
        imem_if.rsp_instr = tv(42);
        #1;
        chk("sp_if_valid", 32'(if_valid), 32'd0);
        chk("sp_err_before", 32'(fetch_err), 32'd0);
        tick();

        imem_if.rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("sp_err_sticky", 32'(fetch_err), 32'd1);
            chk("sp_if_valid_after", 32'(if_valid), 32'd0);
            tick();
        end

        // Reset clears the sticky error and the PC
        rst_n = 1'b0;
        #1;
        chk("rst2_req_valid", 32'(imem_if.req_valid), 32'd0);
        tick();

        #1;
        chk("rst2_err", 32'(fetch_err), 32'd0);
        chk("rst2_req_pc", 32'(imem_if.req_pc), 32'(tv(0)));
        chk("rst2_if_valid", 32'(if_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst2_release_req_valid", 32'(imem_if.req_valid), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ternary_fetch_unit.md
Name: ternary_fetch_unit

Overview:
- IF stage of the ternary pipeline, directly upstream of the IF/ID register.
- Owns the balanced-ternary PC and issues in-order requests to instruction memory.
- Buffers returned instructions in a small in-order fetch queue and presents them to IF/ID.
- Obeys pc_stall and if_id_stall from the hazard unit. A taken-branch redirect squashes buffered and in-flight fetches.

Parameters:
- PC_TRITS, 9, PC width in trits (trit_t from ternary_pkg).
- INSTR_TRITS, 9, instruction width in trits.
- FQ_DEPTH, 2, fetch-queue entries; range 2..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- pc_stall  in  1  freeze PC and request issue.
- if_id_stall  in  1  IF/ID not accepting; hold queue head.
- redirect_valid  in  1  taken branch/jump resolved.
- redirect_pc  in  trit_t[PC_TRITS]  new fetch PC.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_pc  out  trit_t[PC_TRITS]  request address.
- imem_rsp_valid  in  1  in-order response, 1-cycle pulse per accepted request.
- imem_rsp_instr  in  trit_t[INSTR_TRITS]  response data.
- if_valid  out  1  instruction available to IF/ID.
- if_pc  out  trit_t[PC_TRITS]  PC of presented instruction.
- if_instr  out  trit_t[INSTR_TRITS]  presented instruction.
- fetch_err  out  1  sticky protocol error.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous, active-low (rst_n); all state updates on the rising clk edge.
- Reset state:
  - PC = all T_ZERO; queue empty; drop_cnt = 0; fetch_err = 0.
  - Outputs during and after reset: imem_req_valid = 0, if_valid = 0, if_pc/if_instr = all T_ZERO.
  - Reset mid-operation discards all entries and drop counts. Responses arriving afterwards for pre-reset requests are the integrator's responsibility.
- Queue entry state: EMPTY -> RESERVED (request accepted, pc stored) -> FILLED (instr written) -> EMPTY (popped).
  - Allocation and pop are in program order via head/tail pointers that wrap modulo FQ_DEPTH.
  - occ = RESERVED + FILLED entries.
- Request issue:
  - imem_req_valid = !pc_stall && !redirect_valid && (occ + drop_cnt) < FQ_DEPTH. Combinational from registered state and inputs.
  - imem_req_pc = PC.
  - On imem_req_valid && imem_req_ready: reserve the tail entry with the current PC, and PC <= PC + 1.
- PC increment: balanced-ternary +1 with carry ripple from trit 0.
  - T_NEG -> T_ZERO, no carry.
  - T_ZERO -> T_POS, no carry.
  - T_POS -> T_NEG, carry.
  - Wrap-around: all T_POS + 1 = all T_NEG, carry out discarded.
- Response handling:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Else: fill the oldest RESERVED entry.
  - Response with no RESERVED entry and drop_cnt = 0: discard and set fetch_err (clears only on reset).
- Output to IF/ID:
  - if_valid = head entry FILLED. if_pc/if_instr = head fields; held stable while if_valid && if_id_stall.
  - Pop when if_valid && !if_id_stall.
  - A response filling an EMPTY-queue head is visible the cycle after imem_rsp_valid; there is no bypass.
  - Minimum fetch latency: request accept -> if_valid = response latency + 1.
- Stall:
  - pc_stall blocks issue only; responses are still accepted.
  - if_id_stall blocks pop only.
  - Both may be high together (load-use); the queue then fills up to FQ_DEPTH and holds.
- Redirect (priority over everything except reset):
  - Edge effects: PC <= redirect_pc; all entries -> EMPTY; no request issued that cycle.
  - drop_cnt <= drop_cnt + (number of RESERVED entries) - (imem_rsp_valid ? 1 : 0).
  - A response in the redirect cycle is therefore consumed as a drop, or as a pre-existing drop if drop_cnt > 0.
  - A pop in the redirect cycle is permitted; IF/ID flush is handled downstream.
  - if_valid = 0 from the cycle after redirect.
- Simultaneous events in one cycle:
  - Push, fill and pop may all occur in the same cycle.
  - occ counts the allocation and the pop in the same cycle.

Test Plan:
- Reset and straight-line fetch: reset, imem always ready, 1-cycle response latency -> requests at PC 0, +, +-, +0 (trit1..trit0). if_valid first high 2 cycles after the first accept, then one instruction per cycle in order.
- PC wrap-around: redirect_pc = all T_POS, then one accepted request -> next imem_req_pc = all T_NEG.
- Load-use stall: pc_stall = if_id_stall = 1 for 3 cycles with the queue non-empty -> imem_req_valid = 0; if_pc/if_instr stable; queue holds ≤ FQ_DEPTH entries; resume with no loss or duplication.
- Redirect with 2 in flight: FQ_DEPTH = 2, both entries RESERVED, redirect to PC +00 -> drop_cnt = 2. The next 2 responses are discarded, the first request after them is at +00, and if_valid stays 0 until the +00 instruction returns.
- Redirect coincident with response: 1 RESERVED entry plus imem_rsp_valid in the redirect cycle -> drop_cnt = 0. The next response fills the entry for redirect_pc; fetch_err = 0.
- Spurious response: imem_rsp_valid with an empty queue and drop_cnt = 0 -> fetch_err = 1 and stays 1 until rst_n = 0.
